// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with a 2-bit saturating
// direction counter per entry. Lookup is combinational for the fetch stage.
// Resolved branches from MEM update the table on the rising edge. Saturating
// statistics count updates and mispredictions.
module branch_predictor #(
  parameter int XLEN     = 64,
  parameter int IDX_BITS = 4,
  parameter int TAG_BITS = 8,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   fetch_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic              flush,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int ENTRIES = 1 << IDX_BITS;

  // Per-entry state. valid and ctr have a defined reset value. tag and target
  // are meaningless while the entry is invalid, so they are left unreset.
  logic [ENTRIES-1:0] valid_reg;
  logic [1:0]         ctr_reg    [ENTRIES];
  logic [TAG_BITS-1:0] tag_reg   [ENTRIES];
  logic [XLEN-1:0]    target_reg [ENTRIES];

  logic [STAT_W-1:0] stat_updates_reg;
  logic [STAT_W-1:0] stat_mispredicts_reg;

  // The low two PC bits are ignored. The index comes next, and the tag sits above the index.
  logic [IDX_BITS-1:0] fetch_idx;
  logic [TAG_BITS-1:0] fetch_tag;
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0] upd_tag;

  assign fetch_idx = fetch_pc[IDX_BITS+1:2];
  assign fetch_tag = fetch_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign upd_idx   = upd_pc[IDX_BITS+1:2];
  assign upd_tag   = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  // Per-entry tag match vectors. Selecting by index keeps the lookup a plain mux.
  logic [ENTRIES-1:0] fetch_match;
  logic [ENTRIES-1:0] upd_match;

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
      assign fetch_match[gi] = valid_reg[gi] && (tag_reg[gi] == fetch_tag);
      assign upd_match[gi]   = valid_reg[gi] && (tag_reg[gi] == upd_tag);
    end
  endgenerate

  logic       fetch_hit;
  logic       upd_hit;
  logic [1:0] upd_ctr;
  logic [1:0] upd_ctr_next;
  logic       alloc_en;
  logic       write_en;

  // The explicit reset term keeps the outputs quiet while reset is held,
  // independent of how the table flops settle.
  assign fetch_hit = !reset && fetch_match[fetch_idx];
  assign upd_hit   = upd_match[upd_idx];
  assign upd_ctr   = ctr_reg[upd_idx];

  // Lookup: a fall-through prediction unless a hit entry's counter is in a taken state.
  always_comb begin
    pred_hit    = fetch_hit;
    pred_taken  = fetch_hit && ctr_reg[fetch_idx][1];
    pred_target = pred_taken ? target_reg[fetch_idx] : fetch_pc + XLEN'(4);
  end

  // Saturating counter step for a resolved branch that hit.
  always_comb begin
    upd_ctr_next = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != 2'b11) upd_ctr_next = upd_ctr + 2'b01;
    end else begin
      if (upd_ctr != 2'b00) upd_ctr_next = upd_ctr - 2'b01;
    end
  end

  // A taken branch writes tag and target, either as a refresh on a hit or as an
  // allocation on a miss. A flush suppresses all table writes.
  assign alloc_en = upd_valid && !flush && !upd_hit && upd_taken;
  assign write_en = upd_valid && !flush && upd_taken;

  // Valid bits and direction counters. Flush has priority over an update in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_reg[i] <= 2'b01;
    end else if (flush) begin
      valid_reg <= '0;
    end else if (upd_valid) begin
      if (upd_hit) begin
        ctr_reg[upd_idx] <= upd_ctr_next;
      end else if (alloc_en) begin
        valid_reg[upd_idx] <= 1'b1;
        ctr_reg[upd_idx]   <= 2'b10;
      end
    end
  end

  // Tag and target storage, written only by taken branches.
  always_ff @(posedge clk) begin
    if (write_en) begin
      tag_reg[upd_idx]    <= upd_tag;
      target_reg[upd_idx] <= upd_target;
    end
  end

  // Statistics count every update, including updates that coincide with a flush. Both counters stop at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_updates_reg     <= '0;
      stat_mispredicts_reg <= '0;
    end else if (upd_valid) begin
      if (stat_updates_reg != '1)
        stat_updates_reg <= stat_updates_reg + STAT_W'(1);
      if ((upd_pred_taken != upd_taken) && (stat_mispredicts_reg != '1))
        stat_mispredicts_reg <= stat_mispredicts_reg + STAT_W'(1);
    end
  end

  assign stat_updates     = stat_updates_reg;
  assign stat_mispredicts = stat_mispredicts_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor, built with STAT_W = 4 so that
// statistics saturation can be reached quickly.
module tb_branch_predictor;

  localparam int XLEN     = 64;
  localparam int IDX_BITS = 4;
  localparam int TAG_BITS = 8;
  localparam int STAT_W   = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [XLEN-1:0]   fetch_pc = '0;
  logic              pred_hit;
  logic              pred_taken;
  logic [XLEN-1:0]   pred_target;
  logic              upd_valid = 1'b0;
  logic [XLEN-1:0]   upd_pc = '0;
  logic              upd_taken = 1'b0;
  logic [XLEN-1:0]   upd_target = '0;
  logic              upd_pred_taken = 1'b0;
  logic              flush = 1'b0;
  logic [STAT_W-1:0] stat_updates;
  logic [STAT_W-1:0] stat_mispredicts;

  int vectors = 0;
  int miscompares = 0;

  branch_predictor #(
    .XLEN(XLEN), .IDX_BITS(IDX_BITS), .TAG_BITS(TAG_BITS), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken), .flush(flush),
    .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Apply one update for one cycle. The flag also asserts flush in the same cycle.
  task automatic do_update(input logic [63:0] pc, input logic taken, input logic [63:0] tgt,
                           input logic pred, input logic fl);
    @(negedge clk);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt;
    upd_pred_taken = pred; flush = fl;
    @(posedge clk);
    #1;
    upd_valid = 1'b0; flush = 1'b0;
  endtask

  // Mid-cycle lookup: check hit, taken, and target.
  task automatic lookup(input string tag, input logic [63:0] pc, input logic hit,
                        input logic tk, input logic [63:0] tgt);
    @(negedge clk);
    fetch_pc = pc;
    #1;
    check({tag, ".hit"}, 64'(pred_hit), 64'(hit));
    check({tag, ".taken"}, 64'(pred_taken), 64'(tk));
    check({tag, ".target"}, pred_target, tgt);
  endtask

  task automatic stats(input string tag, input int upd, input int mis);
    check({tag, ".updates"}, 64'(stat_updates), 64'(upd));
    check({tag, ".mispredicts"}, 64'(stat_mispredicts), 64'(mis));
  endtask

  initial begin
    // Checks taken while reset is still asserted.
    repeat (2) @(posedge clk);
    lookup("reset", 64'h100, 1'b0, 1'b0, 64'h104);
    stats("reset", 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // First taken update allocates the entry with ctr = 10. This update was mispredicted.
    do_update(64'h100, 1'b1, 64'h80, 1'b0, 1'b0);
    stats("alloc", 1, 1);
    lookup("alloc", 64'h100, 1'b1, 1'b1, 64'h80);

    // Three taken updates move ctr from 10 to 11, where it saturates.
    // One not-taken update then moves ctr to 10, and the entry still predicts taken.
    for (int i = 0; i < 3; i++) do_update(64'h100, 1'b1, 64'h80, 1'b1, 1'b0);
    do_update(64'h100, 1'b0, 64'h0, 1'b1, 1'b0);
    lookup("sat_nt1", 64'h100, 1'b1, 1'b1, 64'h80);
    do_update(64'h100, 1'b0, 64'h0, 1'b1, 1'b0);
    lookup("sat_nt2", 64'h100, 1'b1, 1'b0, 64'h104);
    stats("sat", 6, 3);

    // 0x140 maps to the same index as 0x100 with a different tag, so it evicts 0x100.
    do_update(64'h140, 1'b1, 64'h200, 1'b0, 1'b0);
    lookup("evicted", 64'h100, 1'b0, 1'b0, 64'h104);
    lookup("alias", 64'h140, 1'b1, 1'b1, 64'h200);
    // ctr was freshly set to 10, so a single not-taken update drops the prediction to not-taken.
    do_update(64'h140, 1'b0, 64'h0, 1'b1, 1'b0);
    lookup("alias_nt", 64'h140, 1'b1, 1'b0, 64'h144);
    stats("alias", 8, 5);

    // Flush and a taken update in the same cycle: flush wins, and the update is still counted.
    do_update(64'h300, 1'b1, 64'h400, 1'b1, 1'b1);
    lookup("flush_old", 64'h140, 1'b0, 1'b0, 64'h144);
    lookup("flush_new", 64'h300, 1'b0, 1'b0, 64'h304);
    stats("flush", 9, 5);

    // Not-taken misses only bump stat_updates, which saturates at 4'hF.
    for (int i = 0; i < 6; i++) do_update(64'h500, 1'b0, 64'h0, 1'b0, 1'b0);
    stats("stat_full", 15, 5);
    do_update(64'h500, 1'b0, 64'h0, 1'b0, 1'b0);
    stats("stat_hold", 15, 5);

    // Allocate an entry, then assert reset between edges. The effect must be immediate.
    do_update(64'h600, 1'b1, 64'h700, 1'b1, 1'b0);
    lookup("pre_rst", 64'h600, 1'b1, 1'b1, 64'h700);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    stats("async_rst", 0, 0);
    check("async_rst.hit", 64'(pred_hit), 64'd0);
    check("async_rst.target", pred_target, 64'h604);
    @(negedge clk);
    reset = 1'b0;
    lookup("post_rst", 64'h600, 1'b0, 1'b0, 64'h604);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
